// File: rtl/caf_pkg.sv
// Shared definitions for the CAF Doppler sweep controller: FSM encoding and
// small sizing helpers used by the controller and its peak-hold sub-module.
package caf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TUNE   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } sweep_state_t;

    // The sweep always opens on the zero-offset bin with a positive sign.
    localparam logic FIRST_NEG = 1'b0;

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/caf_peak_hold.sv
// Global peak tracker: the first accepted result of a sweep always loads,
// later ones only when strictly larger, so ties keep the earliest bin.
module caf_peak_hold #(
    parameter int out_max_bits        = 5,
    parameter int length_counter_bits = 3,
    parameter int phase_bits          = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           load,
    input  logic [out_max_bits-1:0]        in_max,
    input  logic [length_counter_bits-1:0] in_index,
    input  logic [phase_bits-1:0]          in_freq_step,
    input  logic                           in_neg,
    output logic [out_max_bits-1:0]        peak_max,
    output logic [length_counter_bits-1:0] peak_index,
    output logic [phase_bits-1:0]          peak_freq_step,
    output logic                           peak_neg
);

    logic have_peak_reg;
    logic take;

    assign take = load && (!have_peak_reg || (in_max > peak_max));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_peak_reg  <= 1'b0;
            peak_max       <= '0;
            peak_index     <= '0;
            peak_freq_step <= '0;
            peak_neg       <= 1'b0;
        end else if (clear) begin
            have_peak_reg  <= 1'b0;
            peak_max       <= '0;
            peak_index     <= '0;
            peak_freq_step <= '0;
            peak_neg       <= 1'b0;
        end else if (take) begin
            have_peak_reg  <= 1'b1;
            peak_max       <= in_max;
            peak_index     <= in_index;
            peak_freq_step <= in_freq_step;
            peak_neg       <= in_neg;
        end
    end

endmodule

// File: rtl/caf_sweep_ctrl.sv
// Steps one caf_slice through a symmetric Doppler sweep (k=0, then +k/-k pairs),
// drains stale results after each retune and reports the global peak once per sweep.
module caf_sweep_ctrl
    import caf_pkg::*;
#(
    parameter int phase_bits          = 10,
    parameter int out_max_bits        = 5,
    parameter int length_counter_bits = 3,
    parameter int num_bins            = 4,
    parameter int bin_bits            = 3,
    parameter int settle_cycles       = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [phase_bits-1:0]          step_size,
    output logic                           busy,
    output logic                           freq_incr_valid,
    output logic [phase_bits-1:0]          freq_step,
    output logic                           neg_shift,
    input  logic                           m_axis_tvalid,
    input  logic [out_max_bits-1:0]        out_max,
    input  logic [length_counter_bits-1:0] index,
    output logic                           s_axis_tready,
    output logic                           s_axis_tvalid,
    output logic [out_max_bits-1:0]        peak_max,
    output logic [length_counter_bits-1:0] peak_index,
    output logic [phase_bits-1:0]          peak_freq_step,
    output logic                           peak_neg,
    input  logic                           m_axis_tready
);

    localparam int settle_bits = cnt_bits(settle_cycles);

    sweep_state_t             state_reg, state_next;
    logic [phase_bits-1:0]    step_reg;
    logic [phase_bits-1:0]    acc_reg;
    logic                     neg_reg;
    logic [bin_bits-1:0]      bin_reg;
    logic [settle_bits-1:0]   settle_cnt_reg, settle_cnt_next;
    logic                     fiv_reg;
    logic                     start_accept;
    logic                     advance;
    logic                     result_accept;
    logic                     last_bin;

    // With num_bins=0 the lone k=0 bin is also the last one.
    assign last_bin = (bin_reg == bin_bits'(num_bins)) && (neg_reg || (num_bins == 0));

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        start_accept    = 1'b0;
        advance         = 1'b0;
        result_accept   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = ST_TUNE;
                end
            end
            ST_TUNE: begin
                settle_cnt_next = '0;
                state_next      = (settle_cycles == 0) ? ST_WAIT : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (int'(settle_cnt_reg) == settle_cycles - 1) begin
                    state_next = ST_WAIT;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            ST_WAIT: begin
                if (m_axis_tvalid) begin
                    result_accept = 1'b1;
                    if (last_bin) begin
                        state_next = ST_REPORT;
                    end else begin
                        advance    = 1'b1;
                        state_next = ST_TUNE;
                    end
                end
            end
            ST_REPORT: begin
                if (m_axis_tready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            fiv_reg        <= 1'b0;
            step_reg       <= '0;
            acc_reg        <= '0;
            neg_reg        <= 1'b0;
            bin_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            fiv_reg        <= start_accept | advance;
            if (start_accept) begin
                step_reg <= step_size;
                acc_reg  <= '0;
                neg_reg  <= FIRST_NEG;
                bin_reg  <= '0;
            end else if (advance) begin
                // +k is followed by -k at the same magnitude; otherwise step k up.
                if (!neg_reg && (bin_reg != '0)) begin
                    neg_reg <= 1'b1;
                end else begin
                    neg_reg <= 1'b0;
                    bin_reg <= bin_reg + 1'b1;
                    acc_reg <= acc_reg + step_reg;
                end
            end
        end
    end

    assign busy            = (state_reg != ST_IDLE);
    assign freq_incr_valid = fiv_reg;
    assign freq_step       = acc_reg;
    assign neg_shift       = neg_reg;
    assign s_axis_tready   = (state_reg == ST_SETTLE) || (state_reg == ST_WAIT);
    assign s_axis_tvalid   = (state_reg == ST_REPORT);

    caf_peak_hold #(
        .out_max_bits       (out_max_bits),
        .length_counter_bits(length_counter_bits),
        .phase_bits         (phase_bits)
    ) u_peak_hold (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_accept),
        .load          (result_accept),
        .in_max        (out_max),
        .in_index      (index),
        .in_freq_step  (acc_reg),
        .in_neg        (neg_reg),
        .peak_max      (peak_max),
        .peak_index    (peak_index),
        .peak_freq_step(peak_freq_step),
        .peak_neg      (peak_neg)
    );

endmodule

// File: tb/tb_caf_sweep_ctrl.sv
// Directed bench for caf_sweep_ctrl: 9-bin sweeps with a scripted slice,
// stale-result drain, phase wrap, report back-pressure and mid-sweep reset.
module tb_caf_sweep_ctrl;

    localparam int NB   = 4;
    localparam int NPOS = 2 * NB + 1;
    localparam int SETL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  step_size;
    logic        busy;
    logic        freq_incr_valid;
    logic [9:0]  freq_step;
    logic        neg_shift;
    logic        m_axis_tvalid;
    logic [4:0]  out_max;
    logic [2:0]  index;
    logic        s_axis_tready;
    logic        s_axis_tvalid;
    logic [4:0]  peak_max;
    logic [2:0]  peak_index;
    logic [9:0]  peak_freq_step;
    logic        peak_neg;
    logic        m_axis_tready;

    int tests = 0;
    int fails = 0;

    logic [4:0] vals [NPOS];
    logic [2:0] idxs [NPOS];

    always #5 clk = ~clk;

    caf_sweep_ctrl #(
        .phase_bits(10), .out_max_bits(5), .length_counter_bits(3),
        .num_bins(NB), .bin_bits(3), .settle_cycles(SETL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_size(step_size),
        .busy(busy), .freq_incr_valid(freq_incr_valid), .freq_step(freq_step),
        .neg_shift(neg_shift), .m_axis_tvalid(m_axis_tvalid), .out_max(out_max),
        .index(index), .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
        .peak_max(peak_max), .peak_index(peak_index), .peak_freq_step(peak_freq_step),
        .peak_neg(peak_neg), .m_axis_tready(m_axis_tready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("[TB] check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_fiv"},   32'(freq_incr_valid), 0);
        chk({tag, "_fstep"}, 32'(freq_step), 0);
        chk({tag, "_neg"},   32'(neg_shift), 0);
        chk({tag, "_srdy"},  32'(s_axis_tready), 0);
        chk({tag, "_svld"},  32'(s_axis_tvalid), 0);
        chk({tag, "_pmax"},  32'(peak_max), 0);
        chk({tag, "_pidx"},  32'(peak_index), 0);
        chk({tag, "_pfrq"},  32'(peak_freq_step), 0);
        chk({tag, "_pneg"},  32'(peak_neg), 0);
    endtask

    // Runs one sweep from IDLE. Inputs change 1 time unit after the rising edge.
    // abort_at >= 0 pulls rst_n low in the WAIT cycle of that sweep position.
    task automatic do_sweep(input logic [9:0] step, input bit stale, input int abort_at);
        int pulses = 0;
        int n;
        int k;
        @(posedge clk); #1;
        start = 1'b1; step_size = step;
        @(posedge clk); #1;
        start = 1'b0; step_size = 10'd0;
        chk("start_latency", 32'(freq_incr_valid), 1);
        for (int p = 0; p < NPOS; p++) begin
            n = 0;
            while (!freq_incr_valid && n < 40) begin
                @(posedge clk); #1; n++;
            end
            chk("fiv_seen", 32'(freq_incr_valid), 1);
            if (freq_incr_valid) pulses++;
            k = (p + 1) / 2;
            chk("freq_step", 32'(freq_step), 32'((k * int'(step)) % 1024));
            chk("neg_shift", 32'(neg_shift), 32'((p > 0 && p % 2 == 0) ? 1 : 0));
            for (int s = 0; s < SETL; s++) begin
                @(posedge clk); #1;
                if (s == 0) chk("fiv_one_cycle", 32'(freq_incr_valid), 0);
                if (stale) begin
                    m_axis_tvalid = 1'b1; out_max = 5'd31; index = 3'd7;
                end
            end
            @(posedge clk); #1;
            m_axis_tvalid = 1'b0;
            chk("wait_ready", 32'(s_axis_tready), 1);
            if (p == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero("rst_mid");
                return;
            end
            m_axis_tvalid = 1'b1; out_max = vals[p]; index = idxs[p];
            @(posedge clk); #1;
            m_axis_tvalid = 1'b0;
        end
        chk("report_valid", 32'(s_axis_tvalid), 1);
        chk("fiv_pulses", 32'(pulses), NPOS);
    endtask

    task automatic accept_report();
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        chk("busy_after_acc", 32'(busy), 0);
        chk("svld_after_acc", 32'(s_axis_tvalid), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; step_size = '0;
        m_axis_tvalid = 1'b0; out_max = '0; index = '0; m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;

        // Sweep with ties: value 7 first appears at k=1 neg=0.
        vals = '{5'd3, 5'd7, 5'd5, 5'd7, 5'd1, 5'd2, 5'd6, 5'd7, 5'd0};
        idxs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        do_sweep(10'd10, 1'b0, -1);
        chk("t1_pmax", 32'(peak_max), 7);
        chk("t1_pfrq", 32'(peak_freq_step), 10);
        chk("t1_pneg", 32'(peak_neg), 0);
        chk("t1_pidx", 32'(peak_index), 1);
        chk("t1_fstep_hold", 32'(freq_step), 40);
        accept_report();

        // Same sweep with out_max=31 presented throughout every settle window.
        do_sweep(10'd10, 1'b1, -1);
        chk("t2_pmax", 32'(peak_max), 7);
        chk("t2_pfrq", 32'(peak_freq_step), 10);
        chk("t2_pidx", 32'(peak_index), 1);
        accept_report();

        // Phase wrap: k=4 -> 1200 mod 1024 = 176; peak at k=3 neg=1 (900).
        vals = '{5'd2, 5'd4, 5'd6, 5'd9, 5'd9, 5'd3, 5'd20, 5'd19, 5'd20};
        idxs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
        do_sweep(10'd300, 1'b0, -1);
        chk("t3_fstep_k4", 32'(freq_step), 176);
        chk("t3_pmax", 32'(peak_max), 20);
        chk("t3_pfrq", 32'(peak_freq_step), 900);
        chk("t3_pneg", 32'(peak_neg), 1);
        chk("t3_pidx", 32'(peak_index), 6);

        // Back-pressure in REPORT with start pulses that must be ignored.
        for (int c = 0; c < 20; c++) begin
            start = (c % 2 == 0);
            step_size = 10'd77;
            @(posedge clk); #1;
            chk("t4_svld", 32'(s_axis_tvalid), 1);
            chk("t4_pmax", 32'(peak_max), 20);
            chk("t4_pfrq", 32'(peak_freq_step), 900);
            chk("t4_fiv", 32'(freq_incr_valid), 0);
        end
        start = 1'b0; step_size = '0;
        accept_report();
        repeat (2) @(posedge clk);
        #1 chk("t4_idle_fstep", 32'(freq_step), 176);
        chk("t4_idle_neg", 32'(neg_shift), 1);

        // Asynchronous reset in WAIT of sweep position 3.
        vals = '{5'd3, 5'd7, 5'd5, 5'd7, 5'd1, 5'd2, 5'd6, 5'd7, 5'd0};
        do_sweep(10'd10, 1'b0, 3);
        repeat (2) @(posedge clk);
        #1 chk_all_zero("rst_hold");
        rst_n = 1'b1;

        // Clean sweep after reset, all-zero magnitudes: first bin wins.
        vals = '{default: 5'd0};
        idxs = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0, 3'd1};
        do_sweep(10'd33, 1'b0, -1);
        chk("t6_pmax", 32'(peak_max), 0);
        chk("t6_pfrq", 32'(peak_freq_step), 0);
        chk("t6_pneg", 32'(peak_neg), 0);
        chk("t6_pidx", 32'(peak_index), 5);
        accept_report();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
